// File: rtl/sha256_w_pipe_sched_ctrl.sv
// Batch scheduler and flow controller for the pipelined SHA-256 message-expansion chain.
// Admits blocks from the nonce generator, drives the shared stage write enable, carries a
// per-block tag alongside the datapath, handles downstream backpressure and batch abort.
module sha256_w_pipe_sched_ctrl #(
    parameter  int DEPTH = 48,
    parameter  int TAG_W = 32,
    parameter  int CNT_W = 32,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] batch_len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    output logic             stage_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [DEPTH-1:0] vld_q;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] retired_q;
    logic [OCC_W-1:0] occ_q;
    logic             done_q;

    logic adv;
    logic acc;
    logic ret;
    logic active;
    logic flush_now;
    logic drain_done;
    logic batch_start;
    logic empty_start;

    // The whole chain advances together unless the last stage holds a block nobody takes.
    assign out_valid   = vld_q[DEPTH-1];
    assign out_tag     = tag_q[DEPTH-1];
    assign adv         = ~(out_valid & ~out_ready);
    assign active      = (state_q == ST_RUN) | (state_q == ST_DRAIN);
    assign stage_en    = adv & active;
    assign in_ready    = (state_q == ST_RUN) & adv & ~abort & (issued_q < len_q);
    assign acc         = in_valid & in_ready;
    assign ret         = out_valid & out_ready;
    assign flush_now   = abort & active;
    assign drain_done  = (state_q == ST_DRAIN) & (occ_q == '0) & (retired_q == len_q);
    assign batch_start = (state_q == ST_IDLE) & start & (batch_len != '0);
    assign empty_start = (state_q == ST_IDLE) & start & (batch_len == '0);

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign aborted    = (state_q == ST_FLUSH);
    assign occupancy  = occ_q;
    assign issued_cnt = issued_q;

    // Next-state logic; abort takes priority over any accept or drain completion.
    always_comb begin
        // NOTE: default assignment first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (batch_start) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)                                     state_d = ST_FLUSH;
                else if (acc && (issued_q == len_q - CNT_W'(1))) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)           state_d = ST_FLUSH;
                else if (drain_done) state_d = ST_IDLE;
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Batch control: state, completion pulse, batch length and issue/retire counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            len_q     <= '0;
            issued_q  <= '0;
            retired_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            done_q  <= empty_start | (drain_done & ~abort);
            if (batch_start) begin
                len_q     <= batch_len;
                issued_q  <= '0;
                retired_q <= '0;
            end else begin
                if (acc) issued_q  <= issued_q + CNT_W'(1);
                if (ret) retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // In-flight block count; an accept and a retire in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (flush_now) begin
            occ_q <= '0;
        end else if (acc && !ret) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (!acc && ret) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    // Valid shift register mirroring the expansion stages; abort empties it at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (flush_now) begin
            vld_q <= '0;
        end else if (stage_en) begin
            vld_q <= {vld_q[DEPTH-2:0], acc};
        end
    end

    // Tag shift register travelling in lockstep with the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the tag array is reset so out_tag reads zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else if (stage_en) begin
            tag_q[0] <= acc ? in_tag : '0;
            for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
        end
    end

endmodule

// File: tb/tb_sha256_w_pipe_sched_ctrl.sv
// Self-checking bench for sha256_w_pipe_sched_ctrl: directed scenarios plus randomized
// batches, all compared against a queue-based reference model of the block stream.
module tb_sha256_w_pipe_sched_ctrl;

    localparam int DEPTH = 48;
    localparam int TAG_W = 32;
    localparam int CNT_W = 32;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] batch_len;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag;
    logic             stage_en;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] issued_cnt;

    sha256_w_pipe_sched_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .batch_len(batch_len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .stage_en(stage_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .busy(busy),
        .done(done), .aborted(aborted), .occupancy(occupancy), .issued_cnt(issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each in-flight block remembers how many advancing edges it has seen.
    typedef struct { logic [TAG_W-1:0] tag; int age; } blk_t;
    typedef enum { P_IDLE, P_RUN, P_DRAIN, P_FLUSH } phase_t;

    blk_t        pipe[$];
    phase_t      ph;
    int unsigned m_len, m_issued, m_retired;
    bit          m_done;
    bit          m_was_aborted;

    int n_total;
    int n_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        ph = P_IDLE;
        m_len = 0; m_issued = 0; m_retired = 0;
        m_done = 0; m_was_aborted = 0;
    endtask

    // One clock cycle: called just after a falling edge with inputs already applied.
    task automatic step();
        bit   e_ov, e_adv, e_se, e_ir, acc, ret, nd, drain_exit;
        blk_t b;
        #1;
        e_ov  = (pipe.size() > 0) && (pipe[0].age == DEPTH);
        e_adv = !(e_ov && !out_ready);
        e_se  = e_adv && (ph == P_RUN || ph == P_DRAIN);
        e_ir  = (ph == P_RUN) && e_adv && !abort && (m_issued < m_len);
        check("out_valid", out_valid, e_ov);
        if (e_ov) check("out_tag", out_tag, pipe[0].tag);
        check("stage_en", stage_en, e_se);
        check("in_ready", in_ready, e_ir);
        check("busy", busy, ph != P_IDLE);
        check("done", done, m_done);
        check("aborted", aborted, ph == P_FLUSH);
        check("done_abort_excl", done & aborted, 0);
        check("occupancy", occupancy, pipe.size());
        check("issued_cnt", issued_cnt, m_issued);
        acc = in_valid && e_ir;
        ret = e_ov && out_ready;
        nd  = (ph == P_IDLE && start && batch_len == 0) ||
              (ph == P_DRAIN && !abort && pipe.size() == 0 && m_retired == m_len);
        drain_exit = (pipe.size() == 0) && (m_retired == m_len);
        @(posedge clk);
        if (rst_n) begin
            case (ph)
                P_IDLE: if (start && batch_len != 0) begin
                    ph = P_RUN; m_len = batch_len; m_issued = 0; m_retired = 0;
                end
                P_RUN, P_DRAIN: begin
                    if (abort) begin
                        pipe.delete();
                        ph = P_FLUSH;
                        m_was_aborted = 1;
                    end else begin
                        if (ph == P_DRAIN && drain_exit) ph = P_IDLE;
                        if (ret) begin
                            m_retired++;
                            void'(pipe.pop_front());
                        end
                        if (e_se) foreach (pipe[i]) pipe[i].age++;
                        if (acc) begin
                            b.tag = in_tag; b.age = 1;
                            pipe.push_back(b);
                            m_issued++;
                            if (m_issued == m_len) ph = P_DRAIN;
                        end
                    end
                end
                P_FLUSH: ph = P_IDLE;
                default: ph = P_IDLE;
            endcase
            m_done = nd;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output int dones);
        int n;
        n = 0; dones = 0;
        while (ph != P_IDLE && n < budget) begin
            step(); n++;
            if (done) dones++;
        end
        check("wait_idle_bound", n < budget, 1);
    endtask

    task automatic run_batch(input int len, input int pv, input int pr, input int abort_at,
                             input int budget, output int dones, output int aborts);
        int n;
        n = 0; dones = 0; aborts = 0;
        m_was_aborted = 0;
        start = 1; batch_len = len; abort = 0; in_valid = 0; out_ready = 1;
        step();
        if (done) dones++;
        while (ph != P_IDLE && n < budget) begin
            in_valid  = ($urandom_range(0, 99) < pv);
            in_tag    = $urandom;
            out_ready = ($urandom_range(0, 99) < pr);
            abort     = (n == abort_at);
            start     = ($urandom_range(0, 7) == 0);
            batch_len = $urandom_range(0, 9);
            step(); n++;
            if (done) dones++;
            if (aborted) aborts++;
        end
        start = 0; abort = 0; in_valid = 0; out_ready = 1;
        step();
        if (done) dones++;
        if (aborted) aborts++;
        check("batch_bound", n < budget, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, d, a, occ0, len, pv, pr, ab, n;
        logic [TAG_W-1:0] tag0;
        n_total = 0; n_bad = 0;
        rst_n = 0; start = 0; batch_len = '0; abort = 0;
        in_valid = 0; in_tag = '0; out_ready = 1;
        model_reset();

        // Reset state before any clock edge.
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_stage_en", stage_en, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_issued", issued_cnt, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        @(negedge clk);
        rst_n = 1;
        step();

        // T1: single block, latency, tag and done pulse.
        start = 1; batch_len = 1;
        step();
        start = 0; in_valid = 1; in_tag = 32'hA5A5_0001;
        step();
        in_valid = 0; lat = 1;
        while (!out_valid && lat < 200) begin step(); lat++; end
        check("t1_latency", lat, DEPTH);
        check("t1_tag", out_tag, 32'hA5A5_0001);
        wait_idle(200, d);
        check("t1_done_cnt", d, 1);
        check("t1_busy", busy, 0);
        step();

        // T2: four back-to-back blocks with free-flowing output.
        run_batch(4, 100, 100, -1, 500, d, a);
        check("t2_done_cnt", d, 1);
        check("t2_abort_cnt", a, 0);
        check("t2_issued", issued_cnt, 4);

        // T3: downstream stall with a valid block at the output.
        start = 1; batch_len = 4;
        step();
        start = 0; in_valid = 1; out_ready = 0; n = 0;
        while (!out_valid && n < 200) begin
            in_tag = 32'h3000 + m_issued;
            step(); n++;
        end
        in_valid = 0;
        check("t3_first_tag", out_tag, 32'h3000);
        check("t3_occ", occupancy, 4);
        tag0 = out_tag; occ0 = occupancy;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_stall_tag", out_tag, tag0);
            check("t3_stall_occ", occupancy, occ0);
            check("t3_stall_en", stage_en, 0);
        end
        out_ready = 1;
        wait_idle(300, d);
        check("t3_done_cnt", d, 1);
        step();

        // T4: abort in RUN with three blocks in flight and a block offered.
        start = 1; batch_len = 6;
        step();
        start = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin in_tag = 32'h4000 + i; step(); end
        check("t4_occ_pre", occupancy, 3);
        abort = 1;
        step();
        abort = 0; in_valid = 0;
        check("t4_out_valid", out_valid, 0);
        check("t4_occ", occupancy, 0);
        check("t4_aborted", aborted, 1);
        check("t4_done", done, 0);
        step();
        check("t4_idle", busy, 0);
        check("t4_aborted_clr", aborted, 0);
        check("t4_issued", issued_cnt, 3);

        // T5: empty batch.
        start = 1; batch_len = 0;
        step();
        start = 0;
        check("t5_done", done, 1);
        check("t5_busy", busy, 0);
        step();
        check("t5_done_clr", done, 0);

        // T6: asynchronous reset while draining, then a normal batch.
        start = 1; batch_len = 2;
        step();
        start = 0; in_valid = 1; n = 0;
        while (ph != P_DRAIN && n < 50) begin in_tag = $urandom; step(); n++; end
        in_valid = 0;
        check("t6_in_drain", busy, 1);
        for (int i = 0; i < 3; i++) step();
        rst_n = 0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_stage_en", stage_en, 0);
        check("t6_in_ready", in_ready, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_aborted", aborted, 0);
        check("t6_occ", occupancy, 0);
        check("t6_issued", issued_cnt, 0);
        check("t6_out_tag", out_tag, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("t6_held", busy, 0);
        rst_n = 1;
        step();
        run_batch(3, 100, 100, -1, 500, d, a);
        check("t6_restart_done", d, 1);
        check("t6_restart_issued", issued_cnt, 3);

        // Randomized batches with random flow control and occasional aborts.
        for (int b = 0; b < 30; b++) begin
            len = $urandom_range(0, 5);
            pv  = $urandom_range(30, 100);
            pr  = $urandom_range(30, 100);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : -1;
            run_batch(len, pv, pr, ab, 2000, d, a);
            if (m_was_aborted) begin
                check("rnd_abort_pulse", a, 1);
                check("rnd_abort_nodone", d, 0);
            end else begin
                check("rnd_done_pulse", d, 1);
                check("rnd_no_abort", a, 0);
                if (len > 0) check("rnd_issued", issued_cnt, len);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
